// File: rtl/amo_req_adapter.sv
// amo_req_adapter: bridges single 32-bit core load/store/AMO requests onto a
// 64-bit SRAM bank port behind the atomic-memory shim. Requests are checked
// and encoded at acceptance, replayed to the bank until granted, and the
// selected 32-bit lane of the read data is returned to the core. Only one
// transaction is in flight at a time.
//
// Handshakes:
//   core side : a request transfers on a cycle with core_req_i=1 and
//               core_gnt_o=1; the core holds its request stable until then.
//               Exactly one core_rvalid_o pulse answers each accepted request.
//   bank side : bank_req_o and every bank_* field stay stable until a cycle
//               with bank_gnt_i=1; bank_rdata_i is valid the following cycle.
module amo_req_adapter #(
    parameter int AddrWidth    = 32,
    parameter int AddrMemWidth = 29
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    // core request / response
    input  logic                    core_req_i,
    output logic                    core_gnt_o,
    input  logic [AddrWidth-1:0]    core_addr_i,
    input  logic                    core_we_i,
    input  logic [3:0]              core_be_i,
    input  logic [31:0]             core_wdata_i,
    input  logic [31:0]             core_swap_i,
    input  logic [3:0]              core_amo_i,
    output logic                    core_rvalid_o,
    output logic [31:0]             core_rdata_o,
    output logic                    core_err_o,
    // bank port
    output logic                    bank_req_o,
    input  logic                    bank_gnt_i,
    output logic [AddrMemWidth-1:0] bank_add_o,
    output logic [3:0]              bank_amo_o,
    output logic                    bank_wen_o,
    output logic [63:0]             bank_wdata_o,
    output logic [7:0]              bank_be_o,
    input  logic [63:0]             bank_rdata_i,
    // current FSM state, for observation only
    output logic [2:0]              dbg_state_o
);

    localparam logic [3:0] AMO_NONE = 4'h0;
    localparam logic [3:0] AMO_CAS  = 4'hA;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RESP  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // latched, already-encoded bank request
    logic [AddrMemWidth-1:0] r_add;
    logic [3:0]              r_amo;
    logic                    r_wen;
    logic [63:0]             r_wdata;
    logic [7:0]              r_be;
    logic                    r_lane_hi;
    logic [31:0]             r_rdata;

    // request decode
    logic        w_is_amo;
    logic        w_is_cas;
    logic        w_lane_hi;
    logic        w_illegal;
    logic [63:0] w_wdata_enc;
    logic [7:0]  w_be_enc;
    logic        w_accept;

    // FSM-derived controls
    logic w_gnt;
    logic w_issue;
    logic w_rvalid;
    logic w_err;

    assign w_is_amo  = (core_amo_i != AMO_NONE);
    assign w_is_cas  = (core_amo_i == AMO_CAS);
    assign w_lane_hi = core_addr_i[2];

    // Illegal: misaligned AMO, unknown opcode, CAS on the upper lane (the shim
    // only compares the lower lane), or a plain access with no bytes enabled.
    assign w_illegal = (w_is_amo && (core_addr_i[1:0] != 2'b00))
                     || (core_amo_i > AMO_CAS)
                     || (w_is_cas && w_lane_hi)
                     || (!w_is_amo && (core_be_i == 4'h0));

    // CAS carries the new value in the upper half and the compare value in
    // the lower half; everything else replicates the operand into both lanes.
    assign w_wdata_enc = w_is_cas ? {core_swap_i, core_wdata_i}
                                  : {core_wdata_i, core_wdata_i};

    // Byte-enable encoding: AMOs always cover the whole selected word.
    always_comb begin
        w_be_enc = 8'h00;
        if (w_is_cas) begin
            w_be_enc = 8'h0F;
        end else if (w_is_amo) begin
            w_be_enc = w_lane_hi ? 8'hF0 : 8'h0F;
        end else begin
            w_be_enc = w_lane_hi ? {core_be_i, 4'h0} : {4'h0, core_be_i};
        end
    end

    assign w_accept = (r_state == ST_IDLE) && core_req_i;

    // Next-state and per-state control outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt       = 1'b0;
        w_issue     = 1'b0;
        w_rvalid    = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_gnt = 1'b1;
                if (core_req_i) begin
                    w_state_nxt = w_illegal ? ST_ERR : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_issue = 1'b1;
                if (bank_gnt_i) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                w_rvalid    = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            ST_ERR: begin
                w_rvalid    = 1'b1;
                w_err       = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register; a reset abandons any transaction without a response.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Latch the encoded request on acceptance so the bank sees stable fields.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_add     <= '0;
            r_amo     <= AMO_NONE;
            r_wen     <= 1'b0;
            r_wdata   <= '0;
            r_be      <= '0;
            r_lane_hi <= 1'b0;
        end else if (w_accept && !w_illegal) begin
            r_add     <= core_addr_i[AddrMemWidth+2:3];
            r_amo     <= core_amo_i;
            r_wen     <= core_we_i && !w_is_amo;
            r_wdata   <= w_wdata_enc;
            r_be      <= w_be_enc;
            r_lane_hi <= w_lane_hi;
        end
    end

    // Response data: cleared on every acceptance (so errors return zero),
    // then loaded with the addressed lane when the bank data arrives.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_rdata <= '0;
        end else if (w_accept) begin
            r_rdata <= '0;
        end else if (r_state == ST_WAIT) begin
            r_rdata <= r_lane_hi ? bank_rdata_i[63:32] : bank_rdata_i[31:0];
        end
    end

    // Core can only be granted outside reset.
    assign core_gnt_o    = w_gnt && rst_ni;
    assign core_rvalid_o = w_rvalid;
    assign core_err_o    = w_err;
    assign core_rdata_o  = r_rdata;

    // Bank fields are driven only while requesting and read as zero otherwise.
    assign bank_req_o   = w_issue;
    assign bank_add_o   = w_issue ? r_add   : '0;
    assign bank_amo_o   = w_issue ? r_amo   : AMO_NONE;
    assign bank_wen_o   = w_issue && r_wen;
    assign bank_wdata_o = w_issue ? r_wdata : '0;
    assign bank_be_o    = w_issue ? r_be    : '0;

    assign dbg_state_o = r_state;

    // Address bits above the bank range do not select anything.
    if (AddrWidth > AddrMemWidth + 3) begin : g_addr_hi
        logic w_unused_addr_hi;
        assign w_unused_addr_hi = ^core_addr_i[AddrWidth-1:AddrMemWidth+3];
    end

endmodule

// File: tb/tb_amo_req_adapter.sv
// Directed bench for amo_req_adapter: a small bank model with shim AMO
// semantics sits on the bank port, and each step checks response data,
// error flag, latency and the encoded bank fields against hand-computed values.
module tb_amo_req_adapter;

  localparam int AW = 32;
  localparam int MW = 29;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          core_req_i;
  logic          core_gnt_o;
  logic [AW-1:0] core_addr_i;
  logic          core_we_i;
  logic [3:0]    core_be_i;
  logic [31:0]   core_wdata_i;
  logic [31:0]   core_swap_i;
  logic [3:0]    core_amo_i;
  logic          core_rvalid_o;
  logic [31:0]   core_rdata_o;
  logic          core_err_o;
  logic          bank_req_o;
  logic          bank_gnt_i;
  logic [MW-1:0] bank_add_o;
  logic [3:0]    bank_amo_o;
  logic          bank_wen_o;
  logic [63:0]   bank_wdata_o;
  logic [7:0]    bank_be_o;
  logic [63:0]   bank_rdata_i;
  logic [2:0]    dbg_state_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  amo_req_adapter #(.AddrWidth(AW), .AddrMemWidth(MW)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .core_req_i   (core_req_i),
    .core_gnt_o   (core_gnt_o),
    .core_addr_i  (core_addr_i),
    .core_we_i    (core_we_i),
    .core_be_i    (core_be_i),
    .core_wdata_i (core_wdata_i),
    .core_swap_i  (core_swap_i),
    .core_amo_i   (core_amo_i),
    .core_rvalid_o(core_rvalid_o),
    .core_rdata_o (core_rdata_o),
    .core_err_o   (core_err_o),
    .bank_req_o   (bank_req_o),
    .bank_gnt_i   (bank_gnt_i),
    .bank_add_o   (bank_add_o),
    .bank_amo_o   (bank_amo_o),
    .bank_wen_o   (bank_wen_o),
    .bank_wdata_o (bank_wdata_o),
    .bank_be_o    (bank_be_o),
    .bank_rdata_i (bank_rdata_i),
    .dbg_state_o  (dbg_state_o)
  );

  // ---------------- bank model ----------------
  logic        gnt_en;
  logic        preload;
  logic [63:0] mem [0:63];
  int          n_bank_req = 0;
  logic [MW-1:0] g_add;
  logic [3:0]    g_amo;
  logic          g_wen;
  logic [63:0]   g_wdata;
  logic [7:0]    g_be;

  assign bank_gnt_i = gnt_en;

  function automatic logic [63:0] apply_op(input logic [63:0] old, input logic [63:0] wd,
                                           input logic [7:0] be, input logic [3:0] amo,
                                           input logic wen);
    logic [63:0] res;
    logic [31:0] o;
    logic [31:0] b;
    logic [31:0] r;
    logic        hi;
    res = old;
    if (amo == 4'h0) begin
      if (wen) for (int i = 0; i < 8; i++) if (be[i]) res[i*8 +: 8] = wd[i*8 +: 8];
      return res;
    end
    hi = be[4];
    o  = hi ? old[63:32] : old[31:0];
    b  = hi ? wd[63:32]  : wd[31:0];
    case (amo)
      4'h1: r = b;
      4'h2: r = o + b;
      4'h3: r = o & b;
      4'h4: r = o | b;
      4'h5: r = o ^ b;
      4'h6: r = ($signed(o) > $signed(b)) ? o : b;
      4'h7: r = (o > b) ? o : b;
      4'h8: r = ($signed(o) < $signed(b)) ? o : b;
      4'h9: r = (o < b) ? o : b;
      4'hA: r = (old[31:0] == wd[31:0]) ? wd[63:32] : old[31:0];
      default: r = o;
    endcase
    if (hi) res[63:32] = r;
    else    res[31:0]  = r;
    return res;
  endfunction

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) mem[i] <= 64'h0;
      mem[0] <= 64'h0000_0000_0000_0005;
      mem[1] <= 64'h0000_0000_0000_0007;
      mem[2] <= 64'h0000_0000_FFFF_FFFC;
    end else begin
      if (bank_req_o) n_bank_req <= n_bank_req + 1;
      if (bank_req_o && bank_gnt_i) begin
        bank_rdata_i <= mem[bank_add_o[5:0]];
        mem[bank_add_o[5:0]] <= apply_op(mem[bank_add_o[5:0]], bank_wdata_o, bank_be_o,
                                         bank_amo_o, bank_wen_o);
        g_add   <= bank_add_o;
        g_amo   <= bank_amo_o;
        g_wen   <= bank_wen_o;
        g_wdata <= bank_wdata_o;
        g_be    <= bank_be_o;
      end
    end
  end

  // ---------------- response monitor ----------------
  logic [32:0] obs_q[$];
  int          obs_cyc_q[$];

  always @(negedge clk) begin
    if (core_rvalid_o) begin
      obs_q.push_back({core_err_o, core_rdata_o});
      obs_cyc_q.push_back(cyc);
    end
  end

  // ---------------- checks and driver tasks ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [31:0] addr, input logic we, input logic [3:0] be,
                       input logic [31:0] wd, input logic [31:0] sw, input logic [3:0] amo,
                       output int acc);
    int k;
    @(negedge clk);
    core_addr_i  = addr;
    core_we_i    = we;
    core_be_i    = be;
    core_wdata_i = wd;
    core_swap_i  = sw;
    core_amo_i   = amo;
    core_req_i   = 1'b1;
    k = 0;
    while (!core_gnt_o && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!core_gnt_o) begin
      n_checks++;
      n_fail++;
      $display("FAIL issue_timeout: observed gnt 0 expected gnt 1 within 50 cycles");
      core_req_i = 1'b0;
      acc = -1;
      return;
    end
    @(posedge clk);
    #1;
    acc = cyc;
    core_req_i = 1'b0;
  endtask

  task automatic get_resp(input string tag, output logic err, output logic [31:0] data,
                          output int rc);
    logic [32:0] v;
    int k;
    k = 0;
    while (obs_q.size() == 0 && k < 50) begin
      @(posedge clk);
      k++;
    end
    if (obs_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_resp_timeout: observed no rvalid expected one within 50 cycles", tag);
      err = 1'bx;
      data = 'x;
      rc = -100;
      return;
    end
    v    = obs_q.pop_front();
    rc   = obs_cyc_q.pop_front();
    err  = v[32];
    data = v[31:0];
  endtask

  // Full transaction; exp_lat == 0 skips the latency check, chk_data == 0
  // skips the data check (stores return no meaningful data).
  task automatic txn(input string tag, input logic [31:0] addr, input logic we,
                     input logic [3:0] be, input logic [31:0] wd, input logic [31:0] sw,
                     input logic [3:0] amo, input logic exp_err, input logic chk_data,
                     input logic [31:0] exp_data, input int exp_lat);
    int acc;
    int rc;
    logic err;
    logic [31:0] data;
    issue(addr, we, be, wd, sw, amo, acc);
    get_resp(tag, err, data, rc);
    chk({tag, "_err"}, 64'(err), 64'(exp_err));
    if (chk_data) chk({tag, "_rdata"}, 64'(data), 64'(exp_data));
    if (exp_lat != 0) chk({tag, "_lat"}, 64'(rc - acc + 1), 64'(exp_lat));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int a0;
    int a1;
    int rc;
    int nb;
    logic e;
    logic [31:0] d;

    rst_ni       = 1'b0;
    preload      = 1'b1;
    gnt_en       = 1'b1;
    core_req_i   = 1'b0;
    core_addr_i  = '0;
    core_we_i    = 1'b0;
    core_be_i    = 4'h0;
    core_wdata_i = '0;
    core_swap_i  = '0;
    core_amo_i   = 4'h0;
    bank_rdata_i = '0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", 64'(core_gnt_o), 64'h0);
    chk("rst_bank_req", 64'(bank_req_o), 64'h0);
    chk("rst_rvalid", 64'(core_rvalid_o), 64'h0);
    chk("rst_err", 64'(core_err_o), 64'h0);
    chk("rst_rdata", 64'(core_rdata_o), 64'h0);
    chk("rst_bank_be", 64'(bank_be_o), 64'h0);
    chk("rst_bank_wdata", bank_wdata_o, 64'h0);
    chk("rst_state", 64'(dbg_state_o), 64'h0);
    rst_ni  = 1'b1;
    preload = 1'b0;
    #1;
    chk("idle_gnt", 64'(core_gnt_o), 64'h1);

    // store to upper lane, then read it back
    txn("st104", 32'h104, 1'b1, 4'hF, 32'hDEADBEEF, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 3);
    chk("st104_add", 64'(g_add), 64'h20);
    chk("st104_be", 64'(g_be), 64'hF0);
    chk("st104_wen", 64'(g_wen), 64'h1);
    chk("st104_amo", 64'(g_amo), 64'h0);
    chk("st104_wdata", g_wdata, 64'hDEADBEEF_DEADBEEF);
    txn("ld104", 32'h104, 1'b0, 4'hF, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'hDEADBEEF, 3);
    chk("ld104_wen", 64'(g_wen), 64'h0);

    // AMO add (we=1 must be ignored), then reload
    txn("add0", 32'h0, 1'b1, 4'hF, 32'h3, 32'h0, 4'h2, 1'b0, 1'b1, 32'h5, 3);
    chk("add0_amo", 64'(g_amo), 64'h2);
    chk("add0_be", 64'(g_be), 64'h0F);
    chk("add0_wen", 64'(g_wen), 64'h0);
    txn("ld0", 32'h0, 1'b0, 4'hF, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h8, 3);

    // CAS success then CAS failure
    txn("cas8a", 32'h8, 1'b0, 4'hF, 32'h7, 32'h9, 4'hA, 1'b0, 1'b1, 32'h7, 3);
    chk("cas8a_wdata", g_wdata, 64'h00000009_00000007);
    chk("cas8a_be", 64'(g_be), 64'h0F);
    chk("cas8a_amo", 64'(g_amo), 64'hA);
    txn("ld8a", 32'h8, 1'b0, 4'hF, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h9, 3);
    txn("cas8b", 32'h8, 1'b0, 4'hF, 32'h7, 32'h55, 4'hA, 1'b0, 1'b1, 32'h9, 3);
    txn("ld8b", 32'h8, 1'b0, 4'hF, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h9, 3);

    // illegal requests: error response, zero data, no bank traffic
    nb = n_bank_req;
    txn("err_cas_c", 32'hC, 1'b0, 4'hF, 32'h7, 32'h9, 4'hA, 1'b1, 1'b1, 32'h0, 0);
    txn("err_swap_2", 32'h2, 1'b0, 4'hF, 32'h1, 32'h0, 4'h1, 1'b1, 1'b1, 32'h0, 0);
    txn("err_amo_b", 32'h0, 1'b0, 4'hF, 32'h1, 32'h0, 4'hB, 1'b1, 1'b1, 32'h0, 0);
    txn("err_be0", 32'h0, 1'b0, 4'h0, 32'h1, 32'h0, 4'h0, 1'b1, 1'b1, 32'h0, 0);
    chk("err_no_bank_req", 64'(n_bank_req), 64'(nb));

    // bank stall: 3 cycles without grant during a load
    gnt_en = 1'b0;
    issue(32'h104, 1'b0, 4'hF, 32'h0, 32'h0, 4'h0, a0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("stall_req", 64'(bank_req_o), 64'h1);
      chk("stall_add", 64'(bank_add_o), 64'h20);
      chk("stall_be", 64'(bank_be_o), 64'hF0);
      chk("stall_wen", 64'(bank_wen_o), 64'h0);
    end
    gnt_en = 1'b1;
    get_resp("stall", e, d, rc);
    chk("stall_err", 64'(e), 64'h0);
    chk("stall_rdata", 64'(d), 64'hDEADBEEF);
    chk("stall_lat", 64'(rc - a0 + 1), 64'd6);

    // AMO max followed immediately by a held load request
    issue(32'h10, 1'b0, 4'hF, 32'h2, 32'h0, 4'h6, a0);
    issue(32'h10, 1'b0, 4'hF, 32'h0, 32'h0, 4'h0, a1);
    get_resp("b2b_max", e, d, rc);
    chk("b2b_max_rdata", 64'(d), 64'hFFFFFFFC);
    chk("b2b_max_lat", 64'(rc - a0 + 1), 64'd3);
    get_resp("b2b_ld", e, d, rc);
    chk("b2b_ld_rdata", 64'(d), 64'h2);
    chk("b2b_ld_lat", 64'(rc - a1 + 1), 64'd3);
    repeat (5) @(posedge clk);
    chk("b2b_no_extra_rvalid", 64'(obs_q.size()), 64'h0);

    // reset while waiting for bank data
    issue(32'h0, 1'b0, 4'hF, 32'h0, 32'h0, 4'h0, a0);
    @(posedge clk);
    #1;
    chk("mid_state_wait", 64'(dbg_state_o), 64'h2);
    @(negedge clk);
    rst_ni = 1'b0;
    @(negedge clk);
    chk("mid_rst_rvalid", 64'(core_rvalid_o), 64'h0);
    chk("mid_rst_bank_req", 64'(bank_req_o), 64'h0);
    chk("mid_rst_rdata", 64'(core_rdata_o), 64'h0);
    chk("mid_rst_gnt", 64'(core_gnt_o), 64'h0);
    chk("mid_rst_state", 64'(dbg_state_o), 64'h0);
    rst_ni = 1'b1;
    repeat (4) @(posedge clk);
    chk("mid_rst_no_rvalid", 64'(obs_q.size()), 64'h0);
    txn("post_rst_ld0", 32'h0, 1'b0, 4'hF, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h8, 3);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
